decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Upstream driver for the 3-to-8 decoder: generates its select A[2:0] and enable E.
//   Steps through the enabled channels in ascending order, holding each for a
//   programmable dwell time, in single-pass or continuous (wrap-around) mode.
//   Output A/E connect directly to the decoder's A/E, so Y is one-hot on the active channel.
// PARAMETERS
//   DWELL   4   cycles each channel stays selected (legal range 1..255; 1 = new channel every cycle)
// PORTS
//   clk     in   1  clock, rising edge
//   rst     in   1  asynchronous reset, active-high
//   start   in   1  request a scan; sampled in IDLE only
//   stop    in   1  abort the scan in progress
//   mask    in   8  channel enables, bit i = channel i; latched when start is accepted
//   cont    in   1  1 = continuous wrap, 0 = single pass; latched with mask
//   A       out  3  decoder select (registered)
//   E       out  1  decoder enable (registered)
//   busy    out  1  high while in SCAN
//   done    out  1  one-cycle pulse on single-pass completion
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, A=3'b000, E=0, busy=0, done=0, dwell cnt=0,
//     latched mask=0, latched cont=0. Outputs stay at these values while rst is high.
//   All outputs are registered. There is no combinational path from any input to any output.
//   States: IDLE, SCAN, FIN.
//   IDLE: E=0, busy=0, A holds its last value.
//     start=1 and mask!=0: latch mask/cont; A=lowest set bit of mask; E=1; busy=1; cnt=0; go SCAN.
//       A/E are valid on the edge that samples start (1-cycle latency).
//     start=1 and mask==0: go FIN (E stays 0, so no channel is driven).
//   SCAN: E=1, A held; cnt increments each cycle.
//     When cnt==DWELL-1: cnt=0; A=next set bit of latched mask strictly above A.
//       No higher bit set and cont=1: A wraps to the lowest set bit.
//       Only one bit set and cont=1: A is unchanged and dwell restarts.
//       No higher bit set and cont=0: E=0, busy=0, go FIN.
//     Each enabled channel sees exactly DWELL consecutive cycles of E=1.
//     Moving from one channel to the next leaves no gap cycle with E=0.
//   FIN: done=1 for exactly this one cycle; E=0; busy=0; return to IDLE.
//   Priority in SCAN: stop > dwell expiry.
//     stop=1: next edge gives E=0, busy=0, state IDLE; done is not pulsed.
//   start while busy or in FIN: ignored, with no effect on the scan.
//   start and stop together in IDLE: stop wins and the scan does not start.
//   mask/cont changing mid-scan: no effect, because the latched copies are used.
//   cnt width is 8 bits and never exceeds DWELL-1.
//   rst asserted mid-scan: immediate return to reset values. No done pulse.
// TESTING
//   1 Reset: hold rst 3 cycles with start=1 -> A=000, E=0, busy=0, done=0 throughout.
//   2 Single pass, DWELL=4, mask=8'hA5, cont=0:
//       A=0,2,5,7, each held 4 cycles with E=1 (decoder Y=01,04,20,80);
//       then E=0 and busy=0, with done=1 for exactly 1 cycle.
//   3 Continuous, mask=8'h81, cont=1: A sequence 0,7,0,7... with E held at 1;
//       then stop -> E=0 next cycle, busy=0, no done pulse.
//   4 mask=8'h00 start -> E never rises; done pulses once, 2 cycles after start.
//   5 Single channel, mask=8'h10, cont=1: A=4 and E=1 indefinitely.
//       A start pulse and a mask change mid-scan have no effect.
//   6 Async reset mid-scan (A=5, cnt=2): outputs go to reset values before the next edge.
//       A fresh start -> scan restarts at the lowest set bit.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for a 3-to-8 decoder. It walks the enabled channels in ascending
// order and holds each one for DWELL cycles, in single-pass or continuous mode.
module decoder_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] mask,
  input  logic       cont,
  output logic [2:0] A,
  output logic       E,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic       e_q, e_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic       cont_q, cont_d;

  // Index of the lowest set bit; the caller guarantees m is nonzero.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i > int'(cur) && m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] nxt;
  assign nxt = next_above(mask_q, a_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    // done trails the FIN state by one register stage
    done_d  = (state_q == FIN);

    unique case (state_q)
      IDLE: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          if (mask != 8'd0) begin
            mask_d  = mask;
            cont_d  = cont;
            a_d     = lowest_bit(mask);
            e_d     = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = 8'd0;
            state_d = SCAN;
          end else begin
            state_d = FIN;
          end
        end
      end

      SCAN: begin
        if (stop) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = 8'd0;
          if (nxt[3]) begin
            a_d = nxt[2:0];
          end else if (cont_q) begin
            // wrap; with a single enabled bit this restarts the same channel
            a_d = lowest_bit(mask_q);
          end else begin
            e_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      FIN: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      mask_q  <= 8'd0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign A    = a_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Testbench for decoder_scan_sequencer: directed scenarios plus a randomized run,
// all compared against a channel-list reference model.
module tb_decoder_scan_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] mask = 8'd0;
  logic       cont = 1'b0;
  logic [2:0] A;
  logic       E;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  decoder_scan_sequencer #(.DWELL(DWELL)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .mask (mask),
    .cont (cont),
    .A    (A),
    .E    (E),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Reference model: scan progress as a position in the list of enabled channels.
  bit        m_scan, m_fin, m_done, m_e, m_busy, m_cont;
  int        m_ch, m_age;
  bit [7:0]  m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_fin = 0; m_done = 0; m_e = 0; m_busy = 0;
    m_cont = 0; m_ch = 0; m_age = 0; m_mask = 8'd0;
  endtask

  task automatic model_step();
    int  lst[$];
    int  pos;
    bit  was_fin;
    if (rst) begin
      model_reset();
      return;
    end
    was_fin = m_fin;
    m_fin   = 0;
    m_done  = was_fin;
    if (m_scan) begin
      if (stop) begin
        m_scan = 0; m_e = 0; m_busy = 0;
      end else begin
        m_age++;
        if (m_age == DWELL) begin
          m_age = 0;
          for (int i = 0; i < 8; i++) if (m_mask[i]) lst.push_back(i);
          pos = 0;
          foreach (lst[k]) if (lst[k] == m_ch) pos = k;
          if (pos + 1 < lst.size()) m_ch = lst[pos + 1];
          else if (m_cont) m_ch = lst[0];
          else begin
            m_scan = 0; m_e = 0; m_busy = 0; m_fin = 1;
          end
        end
      end
    end else if (!was_fin && start && !stop) begin
      if (mask != 0) begin
        m_mask = mask; m_cont = cont; m_age = 0;
        m_scan = 1; m_e = 1; m_busy = 1;
        m_ch = 0;
        while (!mask[m_ch]) m_ch++;
      end else begin
        m_fin = 1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".A"},    32'(A),    32'(m_ch));
    chk({tag, ".E"},    32'(E),    32'(m_e));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // One clock: advance model with the inputs that the edge samples, then check #1 later.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  int seq_a[$];
  int seq_e[$];
  int done_cnt;
  int exp2[16] = '{0,0,0,0, 2,2,2,2, 5,5,5,5, 7,7,7,7};
  int exp3[16] = '{0,0,0,0, 7,7,7,7, 0,0,0,0, 7,7,7,7};
  int guard;

  initial begin
    model_reset();
    #1;

    // Reset held with start asserted
    rst = 1'b1; start = 1'b1; mask = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      cyc("rst_hold");
      chk("rst_zero", {28'd0, A, E}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    cyc("rst_rel");

    // Single pass A5
    mask = 8'hA5; cont = 1'b0; start = 1'b1;
    cyc("sp_start");
    start = 1'b0;
    seq_a.delete(); seq_a.push_back(int'(A));
    done_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      cyc("sp_run");
      if (E) seq_a.push_back(int'(A));
      if (done) done_cnt++;
    end
    chk("sp_len", 32'(seq_a.size()), 32'd16);
    for (int i = 0; i < 16 && i < seq_a.size(); i++) chk("sp_seq", 32'(seq_a[i]), 32'(exp2[i]));
    chk("sp_done_cnt", 32'(done_cnt), 32'd1);
    chk("sp_idle", {30'd0, E, busy}, 32'd0);

    // Continuous 81 then stop
    mask = 8'h81; cont = 1'b1; start = 1'b1;
    cyc("ct_start");
    start = 1'b0; mask = 8'h3C; cont = 1'b0;
    seq_a.delete(); seq_e.delete();
    seq_a.push_back(int'(A)); seq_e.push_back(int'(E));
    for (int i = 0; i < 15; i++) begin
      cyc("ct_run");
      seq_a.push_back(int'(A)); seq_e.push_back(int'(E));
    end
    for (int i = 0; i < 16; i++) begin
      chk("ct_seq", 32'(seq_a[i]), 32'(exp3[i]));
      chk("ct_e", 32'(seq_e[i]), 32'd1);
    end
    stop = 1'b1;
    cyc("ct_stop");
    stop = 1'b0;
    chk("ct_stop_e", 32'(E), 32'd0);
    chk("ct_stop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("ct_after");
      chk("ct_no_done", 32'(done), 32'd0);
    end

    // Empty mask
    mask = 8'h00; start = 1'b1;
    cyc("z_1");
    start = 1'b0;
    chk("z_e1", 32'(E), 32'd0);
    chk("z_d1", 32'(done), 32'd0);
    cyc("z_2");
    chk("z_d2", 32'(done), 32'd1);
    chk("z_e2", 32'(E), 32'd0);
    cyc("z_3");
    chk("z_d3", 32'(done), 32'd0);

    // Single channel, continuous, with disturbances
    mask = 8'h10; cont = 1'b1; start = 1'b1;
    cyc("one_start");
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 7);
      mask  = (i >= 5) ? 8'hFF : 8'h10;
      cyc("one_run");
      chk("one_a", 32'(A), 32'd4);
      chk("one_e", 32'(E), 32'd1);
    end
    start = 1'b0; stop = 1'b1;
    cyc("one_stop");
    stop = 1'b0;

    // Async reset mid-scan at A=5, cnt=2
    mask = 8'hA5; cont = 1'b1; start = 1'b1;
    cyc("ar_start");
    start = 1'b0;
    guard = 0;
    while (A != 3'd5 && guard < 40) begin
      cyc("ar_seek");
      guard++;
    end
    chk("ar_reached5", 32'(A), 32'd5);
    cyc("ar_c1");
    cyc("ar_c2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_async_A", 32'(A), 32'd0);
    chk("ar_async_E", 32'(E), 32'd0);
    chk("ar_async_busy", 32'(busy), 32'd0);
    cyc("ar_hold");
    rst = 1'b0;
    start = 1'b1; mask = 8'h24;
    cyc("ar_restart");
    start = 1'b0;
    chk("ar_restart_A", 32'(A), 32'd2);
    chk("ar_restart_E", 32'(E), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("ar_post");
      chk("ar_no_done", 32'(done), 32'd0);
    end

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cont  = 1'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      if (rst) begin
        #1;
        model_reset();
        compare_model("rnd_async");
      end
      cyc("rnd");
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
